// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder used as the per-cycle arithmetic slice of the serial adder.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    // Sum and carry of a single bit position.
    always_comb begin
        S    = A ^ B ^ Cin;
        Cout = (A & B) | (Cin & (A ^ B));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: consumes one operand bit per cycle LSB-first and publishes
// the full sum and carry-out only when all WIDTH bits have been processed.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    // Counter value during the final RUN cycle.
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_sum;
    logic fa_cout;

    Full_Adder u_full_adder (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_sum),
        .Cout (fa_cout)
    );

    // Next-state: load on accepted Start, shift one bit per RUN cycle, publish on the last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // Start is deliberately not looked at here.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    s_d     = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits; legal range 2..32.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 Start  input  1  request to begin an addition; sampled on rising CLK.
REQ-005 A  input  WIDTH  first operand; sampled only on an accepted Start.
REQ-006 B  input  WIDTH  second operand; sampled only on an accepted Start.
REQ-007 Cin  input  1  carry-in; sampled only on an accepted Start.
REQ-008 Busy  output  1  high while an addition is in progress.
REQ-009 Done  output  1  one-cycle pulse marking S/Cout updated with a new result.
REQ-010 S  output  WIDTH  sum, registered.
REQ-011 Cout  output  1  carry-out, registered.

Function
REQ-012 The block SHALL use states IDLE, RUN and DONE.
REQ-013 Start SHALL be accepted in IDLE or DONE; accepted Start loads A and B into shift registers, loads the carry register with Cin, clears the bit counter, and moves to RUN.
REQ-014 Start in RUN SHALL be ignored with no effect on operands, counter or result.
REQ-015 Each RUN cycle SHALL add the operand LSBs plus the carry register, shift the sum bit into the MSB of an internal result register, shift both operands right by one, update carry with the bit carry-out, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles, the block SHALL move to DONE, copying the internal result to S and the final carry to Cout in the same edge.
REQ-017 Latency: Done SHALL be high in the cycle following the edge that is WIDTH edges after the edge that accepted Start.
REQ-018 Done SHALL be high only in DONE and only for one cycle; without a new Start, DONE returns to IDLE on the next edge.
REQ-019 Busy SHALL be high exactly in RUN.
REQ-020 S and Cout SHALL hold their last result in IDLE, RUN and DONE until the next completion; partial sums never appear on S.
REQ-021 Result SHALL equal (A + B + Cin) mod 2^WIDTH on S, with bit WIDTH of the sum on Cout.
REQ-022 Start in DONE SHALL begin a new addition with zero idle cycles; Done still pulses for the completed result.
REQ-023 Bit counter width SHALL be clog2(WIDTH+1); no wrap-around is permitted within an operation.

Reset
REQ-024 RST high SHALL immediately force state IDLE, Busy=0, Done=0, S=0, Cout=0, and clear counter, carry and shift registers, independent of CLK.
REQ-025 RST asserted mid-RUN SHALL abandon the operation; no Done pulse follows.
REQ-026 The first Start after RST deasserts SHALL be accepted normally.

Structure
REQ-027 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL reside in shared package adder_pkg.
REQ-028 The per-bit addition SHALL instantiate existing one-bit sub-module Full_Adder (ports A, B, Cin, S, Cout); no other sub-modules.

Verification (WIDTH=8)
REQ-029 Start with A=8'h00, B=8'h00, Cin=0 -> Busy high 8 cycles, Done pulse 8 edges after acceptance, S=8'h00, Cout=0.
REQ-030 A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1; A=8'h3C, B=8'h42, Cin=1 -> S=8'h7F, Cout=0.
REQ-031 Start A=8'h10, B=8'h20, Cin=0, then Start with A=8'hFF, B=8'hFF at RUN cycle 3 -> second Start ignored; S=8'h30, Cout=0.
REQ-032 RST pulsed at RUN cycle 4 of A=8'hAA, B=8'h55 -> outputs 0 immediately, no Done; next Start A=8'h01, B=8'h01 -> S=8'h02.
REQ-033 Start A=8'h80, B=8'h80, Cin=0 held high in the Done cycle with A=8'h01, B=8'h02, Cin=1 -> Done with S=8'h00, Cout=1, then Done 8 edges later with S=8'h04, Cout=0.
REQ-034 Random 500 operations -> S/Cout match the REQ-021 model, every Done interval >= 8 edges.
